// File: rtl/sys_defs.sv
// Shared sizing and types for the rename free list: tag, pointer and counter widths.
// Also holds the modular pointer helper used wherever the circular list is indexed.
package sys_defs;

    localparam int WAY           = 3;
    localparam int ARCH_REG_SIZE = 32;
    localparam int PHY_REG_SIZE  = 64;
    localparam int FL_SIZE       = PHY_REG_SIZE - ARCH_REG_SIZE;

    localparam int PHY_IDX_W  = $clog2(PHY_REG_SIZE);
    localparam int FL_PTR_W   = $clog2(FL_SIZE);
    localparam int FL_CNT_W   = $clog2(FL_SIZE + 1);
    localparam int LANE_CNT_W = $clog2(WAY + 1);

    typedef logic [PHY_IDX_W-1:0]  phy_reg_idx_t;
    typedef logic [FL_PTR_W-1:0]   fl_ptr_t;
    typedef logic [FL_CNT_W-1:0]   fl_cnt_t;
    typedef logic [LANE_CNT_W-1:0] lane_cnt_t;

    // Signed offset from a list pointer, wrapped into [0, FL_SIZE) even when FL_SIZE is not a power of two.
    function automatic fl_ptr_t fl_ptr_add(input fl_ptr_t p, input int off);
        int s;
        s = (int'(p) + off) % FL_SIZE;
        if (s < 0) s = s + FL_SIZE;
        return fl_ptr_t'(s);
    endfunction

endpackage

// File: rtl/lane_prefix_count.sv
// Exclusive prefix popcount and total over a WAY-bit lane mask; purely combinational.
// Used to compact active lanes onto consecutive free-list slots.
module lane_prefix_count
    import sys_defs::*;
(
    input  logic      [WAY-1:0] mask_i,
    output lane_cnt_t [WAY-1:0] prefix_o,
    output lane_cnt_t           total_o
);

    lane_cnt_t acc;

    always_comb begin
        acc      = '0;
        prefix_o = '0;
        for (int i = 0; i < WAY; i++) begin
            prefix_o[i] = acc;
            acc         = acc + lane_cnt_t'(mask_i[i]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/free_list.sv
// Circular free list of physical tags: offers WAY compacted tags per cycle, reclaims Told at retire, restores T on rewind.
// Optional FREE_LIST_CHECK_EN adds a sticky fl_error output flagging illegal allocate/retire/rewind traffic.
module free_list
    import sys_defs::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  lane_cnt_t                   alloc_num,
    input  logic         [WAY-1:0]      alloc_dest_nz,
    output phy_reg_idx_t [WAY-1:0]      free_tag,
    output lane_cnt_t                   free_num,
    input  lane_cnt_t                   retire_num,
    input  phy_reg_idx_t [WAY-1:0]      retire_Told,
    input  lane_cnt_t                   rewind_num,
    input  phy_reg_idx_t [WAY-1:0]      rewind_T
`ifdef FREE_LIST_CHECK_EN
    ,
    output logic                        fl_error
`endif
);

    phy_reg_idx_t entries_q [FL_SIZE];
    phy_reg_idx_t entries_d [FL_SIZE];
    fl_ptr_t      head_q, head_d;
    fl_ptr_t      tail_q, tail_d;
    fl_cnt_t      count_q, count_d;

    logic      [WAY-1:0] alloc_mask, retire_mask, rewind_mask;
    lane_cnt_t [WAY-1:0] alloc_pre, retire_pre, rewind_pre;
    lane_cnt_t           alloc_tot, retire_tot, rewind_tot;
    logic                do_alloc;
    int                  count_sum;

    always_comb begin
        alloc_mask  = '0;
        retire_mask = '0;
        rewind_mask = '0;
        for (int i = 0; i < WAY; i++) begin
            alloc_mask[i]  = (lane_cnt_t'(i) < alloc_num)  && alloc_dest_nz[i];
            retire_mask[i] = (lane_cnt_t'(i) < retire_num) && (retire_Told[i] != '0);
            rewind_mask[i] = (lane_cnt_t'(i) < rewind_num) && (rewind_T[i] != '0);
        end
    end

    lane_prefix_count u_alloc_cnt (
        .mask_i   (alloc_mask),
        .prefix_o (alloc_pre),
        .total_o  (alloc_tot)
    );

    lane_prefix_count u_retire_cnt (
        .mask_i   (retire_mask),
        .prefix_o (retire_pre),
        .total_o  (retire_tot)
    );

    lane_prefix_count u_rewind_cnt (
        .mask_i   (rewind_mask),
        .prefix_o (rewind_pre),
        .total_o  (rewind_tot)
    );

    // Offered tags depend only on registered state and this cycle's alloc lanes, never on retire/rewind.
    always_comb begin
        free_tag = '0;
        for (int i = 0; i < WAY; i++) begin
            free_tag[i] = entries_q[fl_ptr_add(head_q, int'(alloc_pre[i]))];
        end
        free_num = (count_q >= fl_cnt_t'(WAY)) ? lane_cnt_t'(WAY) : lane_cnt_t'(count_q);
    end

    always_comb begin
        do_alloc  = (rewind_num == '0);
        entries_d = entries_q;
        for (int j = 0; j < WAY; j++) begin
            if (retire_mask[j]) begin
                entries_d[fl_ptr_add(tail_q, int'(retire_pre[j]))] = retire_Told[j];
            end
        end
        // Youngest squashed tag goes just below head, older ones further back.
        for (int k = 0; k < WAY; k++) begin
            if (rewind_mask[k]) begin
                entries_d[fl_ptr_add(head_q, -1 - int'(rewind_pre[k]))] = rewind_T[k];
            end
        end
        tail_d    = fl_ptr_add(tail_q, int'(retire_tot));
        head_d    = do_alloc ? fl_ptr_add(head_q, int'(alloc_tot))
                             : fl_ptr_add(head_q, -int'(rewind_tot));
        count_sum = int'(count_q) + int'(retire_tot)
                  + (do_alloc ? -int'(alloc_tot) : int'(rewind_tot));
        count_d   = fl_cnt_t'(count_sum);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < FL_SIZE; k++) begin
                entries_q[k] <= phy_reg_idx_t'(ARCH_REG_SIZE + k);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= fl_cnt_t'(FL_SIZE);
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

`ifdef FREE_LIST_CHECK_EN
    logic fl_err_q;
    logic err_now;

    always_comb begin
        err_now = 1'b0;
        if (do_alloc && (int'(alloc_tot) > int'(count_q))) err_now = 1'b1;
        if (count_sum > FL_SIZE) err_now = 1'b1;
        for (int j = 0; j < WAY; j++) begin
            if (retire_mask[j] && (int'(retire_Told[j]) < ARCH_REG_SIZE)) err_now = 1'b1;
        end
        // A rewound tag must land back in the slot it was originally taken from.
        for (int k = 0; k < WAY; k++) begin
            if (rewind_mask[k]) begin
                if (int'(rewind_T[k]) < ARCH_REG_SIZE) err_now = 1'b1;
                if (entries_q[fl_ptr_add(head_q, -1 - int'(rewind_pre[k]))] != rewind_T[k]) err_now = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fl_err_q <= 1'b0;
        end else begin
            if (err_now) fl_err_q <= 1'b1;
            assert (!err_now) else $error("free_list: illegal allocate/retire/rewind");
        end
    end

    assign fl_error = fl_err_q;
`endif

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed vector table, corner-case sequences, then constrained-random traffic.
// Expected tags come from a queue model of the free region checked through a scoreboard.
module tb_free_list;
    import sys_defs::*;

    typedef phy_reg_idx_t [WAY-1:0] tags_t;

    typedef struct {
        lane_cnt_t      an;
        logic [WAY-1:0] nz;
        lane_cnt_t      rn;
        tags_t          rt;
        lane_cnt_t      wn;
        tags_t          wt;
        lane_cnt_t      exp_num;
        tags_t          exp_tag;
        logic [WAY-1:0] exp_chk;
    } vec_t;

    typedef struct {
        lane_cnt_t      num;
        tags_t          tag;
        logic [WAY-1:0] chk;
    } sb_t;

    logic         clock = 1'b0;
    logic         reset;
    lane_cnt_t    alloc_num;
    logic [WAY-1:0] alloc_dest_nz;
    tags_t        free_tag;
    lane_cnt_t    free_num;
    lane_cnt_t    retire_num;
    tags_t        retire_Told;
    lane_cnt_t    rewind_num;
    tags_t        rewind_T;
`ifdef FREE_LIST_CHECK_EN
    logic         fl_error;
`endif

    always #5 clock = ~clock;

    free_list dut (
        .clock         (clock),
        .reset         (reset),
        .alloc_num     (alloc_num),
        .alloc_dest_nz (alloc_dest_nz),
        .free_tag      (free_tag),
        .free_num      (free_num),
        .retire_num    (retire_num),
        .retire_Told   (retire_Told),
        .rewind_num    (rewind_num),
        .rewind_T      (rewind_T)
`ifdef FREE_LIST_CHECK_EN
        ,
        .fl_error      (fl_error)
`endif
    );

    sb_t          sbq [$];
    phy_reg_idx_t fq [$];
    phy_reg_idx_t alog [$];
    vec_t         vt [7];
    int           n_vec = 0;
    int           n_err = 0;

    function automatic tags_t tg(input int a, input int b, input int c);
        tags_t t;
        t[0] = phy_reg_idx_t'(a);
        t[1] = phy_reg_idx_t'(b);
        t[2] = phy_reg_idx_t'(c);
        return t;
    endfunction

    function automatic vec_t mkv(input int an, input int nz, input int rn, input tags_t rt,
                                 input int wn, input tags_t wt, input int en, input tags_t et,
                                 input int chk);
        vec_t v;
        v.an = lane_cnt_t'(an);  v.nz = 3'(nz);  v.rn = lane_cnt_t'(rn);  v.rt = rt;
        v.wn = lane_cnt_t'(wn);  v.wt = wt;      v.exp_num = lane_cnt_t'(en);
        v.exp_tag = et;          v.exp_chk = 3'(chk);
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        alloc_num = '0; alloc_dest_nz = '0; retire_num = '0; retire_Told = '0;
        rewind_num = '0; rewind_T = '0;
        @(posedge clock);
        #1 reset = 1'b1;
        fq.delete();
        for (int k = 0; k < FL_SIZE; k++) fq.push_back(phy_reg_idx_t'(ARCH_REG_SIZE + k));
        alog.delete();
        sbq.delete();
    endtask

    // Drive one cycle of stimulus, predict outputs from the model, then compare via the scoreboard.
    task automatic drive(input lane_cnt_t an, input logic [WAY-1:0] nz, input lane_cnt_t rn,
                         input tags_t rt, input lane_cnt_t wn, input tags_t wt);
        sb_t e;
        sb_t g;
        int  p;
        @(negedge clock);
        alloc_num = an; alloc_dest_nz = nz; retire_num = rn; retire_Told = rt;
        rewind_num = wn; rewind_T = wt;
        p = 0;
        e.tag = '0;
        e.chk = '0;
        for (int i = 0; i < WAY; i++) begin
            if ((i < int'(an)) && nz[i]) begin
                if (p < fq.size()) begin
                    e.tag[i] = fq[p];
                    e.chk[i] = 1'b1;
                end
                p++;
            end
        end
        e.num = (fq.size() >= WAY) ? lane_cnt_t'(WAY) : lane_cnt_t'(fq.size());
        sbq.push_back(e);
        #1;
        g = sbq.pop_front();
        check("free_num", int'(free_num), int'(g.num));
        for (int i = 0; i < WAY; i++) begin
            if (g.chk[i]) check($sformatf("free_tag[%0d]", i), int'(free_tag[i]), int'(g.tag[i]));
        end
    endtask

    task automatic commit();
        @(posedge clock);
        if (rewind_num == '0) begin
            for (int i = 0; i < WAY; i++) begin
                if ((i < int'(alloc_num)) && alloc_dest_nz[i] && (fq.size() > 0)) begin
                    alog.push_back(fq.pop_front());
                end
            end
        end
        for (int j = 0; j < WAY; j++) begin
            if ((j < int'(retire_num)) && (retire_Told[j] != '0)) fq.push_back(retire_Told[j]);
        end
        if (rewind_num != '0) begin
            for (int k = 0; k < WAY; k++) begin
                if ((k < int'(rewind_num)) && (rewind_T[k] != '0)) fq.push_front(rewind_T[k]);
            end
        end
    endtask

    task automatic step(input lane_cnt_t an, input logic [WAY-1:0] nz, input lane_cnt_t rn,
                        input tags_t rt, input lane_cnt_t wn, input tags_t wt);
        drive(an, nz, rn, rt, wn, wt);
        commit();
    endtask

    task automatic retire_from_log(input int n);
        tags_t t;
        t = '0;
        for (int j = 0; j < n; j++) t[j] = alog.pop_front();
        step(2'd0, 3'b000, lane_cnt_t'(n), t, 2'd0, '0);
    endtask

    initial begin
        tags_t z;
        z = '0;
        vt[0] = mkv(3, 'b111, 0, z, 0, z, 3, tg(32, 33, 34), 'b111);
        vt[1] = mkv(3, 'b101, 0, z, 0, z, 3, tg(35, 0, 36), 'b101);
        vt[2] = mkv(3, 'b111, 0, z, 0, z, 3, tg(37, 38, 39), 'b111);
        vt[3] = mkv(3, 'b111, 0, z, 2, tg(39, 38, 0), 3, tg(40, 41, 42), 'b111);
        vt[4] = mkv(1, 'b001, 0, z, 0, z, 3, tg(38, 0, 0), 'b001);
        vt[5] = mkv(0, 'b000, 3, tg(5, 0, 9), 0, z, 3, tg(39, 0, 0), 'b001);
        vt[6] = mkv(2, 'b011, 0, z, 0, z, 3, tg(39, 40, 0), 'b011);

        do_reset();
`ifdef FREE_LIST_CHECK_EN
        #1 check("fl_error after reset", int'(fl_error), 0);
`endif
        for (int v = 0; v < 7; v++) begin
            drive(vt[v].an, vt[v].nz, vt[v].rn, vt[v].rt, vt[v].wn, vt[v].wt);
            check($sformatf("vec%0d free_num", v), int'(free_num), int'(vt[v].exp_num));
            for (int i = 0; i < WAY; i++) begin
                if (vt[v].exp_chk[i])
                    check($sformatf("vec%0d free_tag[%0d]", v, i), int'(free_tag[i]), int'(vt[v].exp_tag[i]));
            end
            commit();
        end

        // Drain to empty; the retired 5 and 9 surface after head wraps past slot 31.
        repeat (7) step(2'd3, 3'b111, 2'd0, '0, 2'd0, '0);
        drive(2'd3, 3'b111, 2'd0, '0, 2'd0, '0);
        check("drain tag62", int'(free_tag[0]), 62);
        check("drain tag63", int'(free_tag[1]), 63);
        check("retired tag5", int'(free_tag[2]), 5);
        commit();
        drive(2'd1, 3'b001, 2'd0, '0, 2'd0, '0);
        check("free_num one left", int'(free_num), 1);
        check("retired tag9", int'(free_tag[0]), 9);
        commit();
        drive(2'd0, 3'b000, 2'd0, '0, 2'd0, '0);
        check("free_num empty", int'(free_num), 0);
        commit();
`ifdef FREE_LIST_CHECK_EN
        step(2'd1, 3'b001, 2'd0, '0, 2'd0, '0);
        #1 check("fl_error on over-alloc", int'(fl_error), 1);
`endif

        // Wrap sequence: mid-operation reset, then place tail at slot 31 and retire 2,3 across the wrap.
        do_reset();
        repeat (10) step(2'd3, 3'b111, 2'd0, '0, 2'd0, '0);
        step(2'd2, 3'b011, 2'd0, '0, 2'd0, '0);
        repeat (10) retire_from_log(3);
        retire_from_log(1);
        repeat (10) step(2'd3, 3'b111, 2'd0, '0, 2'd0, '0);
        step(2'd0, 3'b000, 2'd2, tg(2, 3, 0), 2'd0, '0);
        drive(2'd3, 3'b111, 2'd0, '0, 2'd0, '0);
        check("wrap free_num", int'(free_num), 3);
        check("wrap tag2", int'(free_tag[1]), 2);
        check("wrap tag3", int'(free_tag[2]), 3);
        commit();

        // Random legal traffic: retire oldest allocated, rewind youngest, never over-allocate.
        do_reset();
        repeat (3000) begin
            lane_cnt_t      an, rn, wn;
            logic [WAY-1:0] nz;
            tags_t          rt, wt;
            int             a;
            wn = '0; wt = '0; rt = '0;
            if (($urandom_range(0, 7) == 0) && (alog.size() > 0)) begin
                wn = lane_cnt_t'($urandom_range(1, 3));
                for (int k = 0; k < int'(wn); k++) begin
                    if (($urandom_range(0, 3) != 0) && (alog.size() > 0)) wt[k] = alog.pop_back();
                end
            end
            rn = lane_cnt_t'($urandom_range(0, 3));
            for (int j = 0; j < WAY; j++) begin
                if (j < int'(rn)) begin
                    if (($urandom_range(0, 3) != 0) && (alog.size() > 0)) rt[j] = alog.pop_front();
                end else begin
                    rt[j] = phy_reg_idx_t'($urandom);
                end
            end
            an = lane_cnt_t'($urandom_range(0, 3));
            nz = 3'($urandom);
            for (int i = WAY - 1; i >= 0; i--) begin
                a = 0;
                for (int m = 0; m < WAY; m++) if ((m < int'(an)) && nz[m]) a++;
                if (a > fq.size()) nz[i] = 1'b0;
            end
            step(an, nz, rn, rt, wn, wt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/free_list.md
# free_list

Circular buffer of unallocated physical register tags that sits directly upstream of the rename map table. Each cycle it offers up to `WAY` compacted free tags for dispatch. It reclaims `Told` tags at retire and restores squashed `T` tags on branch rewind by moving its head pointer back. It also reports how many tags are available, so dispatch can throttle.

## Interface
- `WAY`, 3: superscalar width (lanes).
- `ARCH_REG_SIZE`, 32: architectural registers; tags `0..ARCH_REG_SIZE-1` are mapped at reset.
- `PHY_REG_SIZE`, 64: physical registers; `FL_SIZE = PHY_REG_SIZE - ARCH_REG_SIZE` list entries.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low; state initialises on a rising edge with `reset==0`.
- `alloc_num` in `$clog2(WAY+1)`: dispatch lanes valid this cycle (lanes `0..alloc_num-1`).
- `alloc_dest_nz` in `WAY`: lane has a non-zero architectural destination and consumes a tag.
- `free_tag` out `WAY`×`phy_reg_idx_t`: tag lane `i` must use. Compacted over allocating lanes below `i`.
- `free_num` out `$clog2(WAY+1)`: `min(count, WAY)`.
- `retire_num` in `$clog2(WAY+1)`: retiring ROB entries this cycle.
- `retire_Told` in `WAY`×`phy_reg_idx_t`: freed tags; a value of 0 means no tag.
- `rewind_num` in `$clog2(WAY+1)`: squashed instructions this cycle, youngest first.
- `rewind_T` in `WAY`×`phy_reg_idx_t`: tags of the squashed instructions; 0 means no tag.

## Operation
- State:
  - `entries[FL_SIZE]` of tags.
  - `head` and `tail` pointers, `$clog2(FL_SIZE)` bits, wrapping modulo `FL_SIZE`.
  - `count`, `$clog2(FL_SIZE+1)` bits.
  - Free region is `[head, head+count)`.
- Reset: `entries[k]=ARCH_REG_SIZE+k`, `head=0`, `tail=0`, `count=FL_SIZE`.
- Allocation:
  - Applies only when `rewind_num==0`.
  - Allocating lanes are `i<alloc_num && alloc_dest_nz[i]`; their number is `A`.
  - `free_tag[i] = entries[head + popcount(allocating lanes < i)]`.
  - `head += A`, `count -= A`.
  - Non-allocating lanes still drive a `free_tag`, which is ignored.
- Retire:
  - Each lane `j<retire_num` with `retire_Told[j]!=0` is written at `tail + popcount(earlier such lanes)`.
  - `tail += R` and `count += R`, where `R` is the number of such lanes.
  - Tag 0 is never freed.
- Rewind (`rewind_num!=0`):
  - Non-zero `rewind_T[k]`, in order, are written at `head-1`, `head-2`, and so on.
  - `head -= W` and `count += W`, where `W` is the number of non-zero `rewind_T`.
  - Allocation is suppressed in the same cycle, matching the map table.
- Simultaneous events:
  - Retire and rewind both apply: `count += R + W`.
  - Retire and allocate both apply: `count += R - A`.
  - Rewind and retire write disjoint slots, because `count + R + W <= FL_SIZE` is a system invariant.
- Empty: `free_num=0`. Dispatch must not request more allocating lanes than `free_num`; doing so is illegal.
- Full: `count==FL_SIZE`. Any retire or rewind with a non-zero tag is then illegal.

## Timing
- `free_tag` and `free_num` are combinational from registered `head`/`count` plus the same-cycle `alloc_*` inputs. There is no path from `retire_*`/`rewind_*`.
- Freed and rewound tags become visible one cycle later. There is no same-cycle bypass.
- Reset values:
  - `free_num=WAY`.
  - `free_tag` with all lanes allocating is `32,33,34`.
  - `fl_error=0`.
- Reset mid-operation discards all in-flight pointers and returns the list to the reset image on that edge.

## Configuration
- `FREE_LIST_CHECK_EN` defined:
  - Adds output `fl_error` (1 bit, sticky until reset).
  - Set on: allocation beyond `count`; `count` overflow past `FL_SIZE`; a retired or rewound tag below `ARCH_REG_SIZE` other than 0; a rewound tag whose restored slot already held a different value than the one written.
  - A simulation `$error` fires on the same conditions.
- Undefined: the port and the checking logic are absent. Illegal stimulus gives undefined list contents.

## Structure
- Shared package `sys_defs`: `phy_reg_idx_t`, `FL_SIZE`, `fl_ptr_t`, `fl_cnt_t`.
- One sub-module, `lane_prefix_count`. It computes exclusive prefix popcounts and the total over a `WAY`-bit mask. It is instanced three times: alloc, retire and rewind.

## Test plan
- Reset, then `alloc_num=3`, `alloc_dest_nz=3'b111` → `free_tag=32,33,34`; next cycle `free_tag[0]=35`, `count=29`.
- `alloc_num=3`, `alloc_dest_nz=3'b101` → lane0=32, lane2=33 (lane1 ignored); `head=2`.
- Allocate 32 tags, then request 1 → `free_num=0`. With the macro defined, allocating anyway sets `fl_error=1`.
- After allocating `32..37`: `rewind_num=2`, `rewind_T=37,36`, with `alloc_num=3` in the same cycle → no allocation, `head=4`; next cycle `free_tag[0]=36`.
- `retire_num=3`, `retire_Told=5,0,9` → `count+=2`; entries 5 and 9 appear at the old `tail` and `tail+1`; tag 0 is not inserted.
- Wrap: cycle until `head` and `tail` pass 31. Retire `2,3` at `tail=31` → stored at slots 31 and 0; later allocation returns 2 then 3.
